// File: rtl/axi_xbar_1ton.sv
// axi_xbar_1ton: AXI4 one-master to NSLV-slave crossbar.
//
// Routes the AR/R and AW/W/B channels of a single master to one of NSLV
// slaves. The target is chosen by base/mask address decode. The lowest
// matching index wins. The route is latched at address acceptance, so later
// changes of the master address cannot reroute a transaction in flight.
// Addresses that match no slave go to an internal DECERR responder. That
// responder returns full-length read bursts and swallows write bursts.
// Read and write paths are independent. Each path allows one transaction
// outstanding. All channels pass through combinationally with zero latency.
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   m_ar*/m_arready               master read address channel
//   m_r*/m_rready                 master read data channel
//   m_aw*/m_awready               master write address channel
//   m_w*/m_wready                 master write data channel
//   m_b*/m_bready                 master write response channel
//   s_ar*, s_aw*, s_w*            per-slave request channels, slot i = slave i
//   s_arready, s_awready, s_wready  per-slave request ready
//   s_r*, s_b*                    per-slave response channels
//   s_rready, s_bready            per-slave response ready
module axi_xbar_1ton #(
  parameter int NSLV = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h8000_0000, 32'h0200_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hFFFF_0000}
) (
  input  logic                     clock,
  input  logic                     reset,
  // master read address
  input  logic                     m_arvalid,
  input  logic [ADDR_W-1:0]        m_araddr,
  input  logic [ID_W-1:0]          m_arid,
  input  logic [7:0]               m_arlen,
  input  logic [2:0]               m_arsize,
  input  logic [1:0]               m_arburst,
  output logic                     m_arready,
  // master read data
  output logic                     m_rvalid,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [ID_W-1:0]          m_rid,
  input  logic                     m_rready,
  // master write address
  input  logic                     m_awvalid,
  input  logic [ADDR_W-1:0]        m_awaddr,
  input  logic [ID_W-1:0]          m_awid,
  input  logic [7:0]               m_awlen,
  input  logic [2:0]               m_awsize,
  input  logic [1:0]               m_awburst,
  output logic                     m_awready,
  // master write data
  input  logic                     m_wvalid,
  input  logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W/8-1:0]      m_wstrb,
  input  logic                     m_wlast,
  output logic                     m_wready,
  // master write response
  output logic                     m_bvalid,
  output logic [1:0]               m_bresp,
  output logic [ID_W-1:0]          m_bid,
  input  logic                     m_bready,
  // slave read address
  output logic [NSLV-1:0]          s_arvalid,
  output logic [NSLV*ADDR_W-1:0]   s_araddr,
  output logic [NSLV*ID_W-1:0]     s_arid,
  output logic [NSLV*8-1:0]        s_arlen,
  output logic [NSLV*3-1:0]        s_arsize,
  output logic [NSLV*2-1:0]        s_arburst,
  input  logic [NSLV-1:0]          s_arready,
  // slave read data
  input  logic [NSLV-1:0]          s_rvalid,
  input  logic [NSLV*DATA_W-1:0]   s_rdata,
  input  logic [NSLV*2-1:0]        s_rresp,
  input  logic [NSLV-1:0]          s_rlast,
  input  logic [NSLV*ID_W-1:0]     s_rid,
  output logic [NSLV-1:0]          s_rready,
  // slave write address
  output logic [NSLV-1:0]          s_awvalid,
  output logic [NSLV*ADDR_W-1:0]   s_awaddr,
  output logic [NSLV*ID_W-1:0]     s_awid,
  output logic [NSLV*8-1:0]        s_awlen,
  output logic [NSLV*3-1:0]        s_awsize,
  output logic [NSLV*2-1:0]        s_awburst,
  input  logic [NSLV-1:0]          s_awready,
  // slave write data
  output logic [NSLV-1:0]          s_wvalid,
  output logic [NSLV*DATA_W-1:0]   s_wdata,
  output logic [NSLV*DATA_W/8-1:0] s_wstrb,
  output logic [NSLV-1:0]          s_wlast,
  input  logic [NSLV-1:0]          s_wready,
  // slave write response
  input  logic [NSLV-1:0]          s_bvalid,
  input  logic [NSLV*2-1:0]        s_bresp,
  input  logic [NSLV*ID_W-1:0]     s_bid,
  output logic [NSLV-1:0]          s_bready
);

  localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_ERR} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  // Returns {hit, index}. The loop scans downward so the lowest match is
  // written last and therefore wins.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
        res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  logic [SEL_W:0]   ar_dec, aw_dec;
  logic             ar_hit, aw_hit;
  logic [SEL_W-1:0] ar_idx, aw_idx;

  assign ar_dec = decode(m_araddr);
  assign aw_dec = decode(m_awaddr);
  assign ar_hit = ar_dec[SEL_W];
  assign aw_hit = aw_dec[SEL_W];
  assign ar_idx = ar_dec[SEL_W-1:0];
  assign aw_idx = aw_dec[SEL_W-1:0];

  rstate_t          rstate, rstate_nxt;
  wstate_t          wstate, wstate_nxt;
  logic [SEL_W-1:0] rsel, rsel_nxt, wsel, wsel_nxt;
  logic [8:0]       cnt, cnt_nxt;   // DECERR beats left; arlen=255 needs 256
  logic             werr, werr_nxt; // current write targets the DECERR sink
  logic [ID_W-1:0]  rid_q, rid_nxt, bid_q, bid_nxt;

  // control state
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate <= R_IDLE;
      wstate <= W_IDLE;
      rsel   <= '0;
      wsel   <= '0;
      cnt    <= '0;
      werr   <= 1'b0;
    end else begin
      rstate <= rstate_nxt;
      wstate <= wstate_nxt;
      rsel   <= rsel_nxt;
      wsel   <= wsel_nxt;
      cnt    <= cnt_nxt;
      werr   <= werr_nxt;
    end
  end

  // DECERR ids are data; they are only visible in the error states
  always_ff @(posedge clock) begin
    rid_q <= rid_nxt;
    bid_q <= bid_nxt;
  end

  // read path
  always_comb begin
    rstate_nxt = rstate;
    rsel_nxt   = rsel;
    cnt_nxt    = cnt;
    rid_nxt    = rid_q;
    m_arready  = 1'b0;
    s_arvalid  = '0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = '0;
    m_rlast    = 1'b0;
    m_rid      = '0;
    s_rready   = '0;
    case (rstate)
      R_IDLE: begin
        if (ar_hit) begin
          s_arvalid[ar_idx]                         = m_arvalid;
          s_araddr[int'(ar_idx)*ADDR_W +: ADDR_W]   = m_araddr;
          s_arid[int'(ar_idx)*ID_W +: ID_W]         = m_arid;
          s_arlen[int'(ar_idx)*8 +: 8]              = m_arlen;
          s_arsize[int'(ar_idx)*3 +: 3]             = m_arsize;
          s_arburst[int'(ar_idx)*2 +: 2]            = m_arburst;
          m_arready                                 = s_arready[ar_idx];
          if (m_arvalid && s_arready[ar_idx]) begin
            rsel_nxt   = ar_idx;
            rstate_nxt = R_DATA;
          end
        end else begin
          m_arready = 1'b1;
          if (m_arvalid) begin
            rid_nxt    = m_arid;
            cnt_nxt    = {1'b0, m_arlen} + 9'd1;
            rstate_nxt = R_ERR;
          end
        end
      end
      R_DATA: begin
        m_rvalid         = s_rvalid[rsel];
        m_rdata          = s_rdata[int'(rsel)*DATA_W +: DATA_W];
        m_rresp          = s_rresp[int'(rsel)*2 +: 2];
        m_rlast          = s_rlast[rsel];
        m_rid            = s_rid[int'(rsel)*ID_W +: ID_W];
        s_rready[rsel]   = m_rready;
        if (s_rvalid[rsel] && m_rready && s_rlast[rsel])
          rstate_nxt = R_IDLE;
      end
      R_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
        m_rid    = rid_q;
        m_rlast  = (cnt == 9'd1);
        if (m_rready) begin
          cnt_nxt = cnt - 9'd1;
          if (cnt == 9'd1)
            rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // write path
  always_comb begin
    wstate_nxt = wstate;
    wsel_nxt   = wsel;
    werr_nxt   = werr;
    bid_nxt    = bid_q;
    m_awready  = 1'b0;
    s_awvalid  = '0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    m_wready   = 1'b0;
    s_wvalid   = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = '0;
    m_bvalid   = 1'b0;
    m_bresp    = '0;
    m_bid      = '0;
    s_bready   = '0;
    case (wstate)
      // W beats are held off (m_wready=0) until the address is accepted
      W_IDLE: begin
        if (aw_hit) begin
          s_awvalid[aw_idx]                         = m_awvalid;
          s_awaddr[int'(aw_idx)*ADDR_W +: ADDR_W]   = m_awaddr;
          s_awid[int'(aw_idx)*ID_W +: ID_W]         = m_awid;
          s_awlen[int'(aw_idx)*8 +: 8]              = m_awlen;
          s_awsize[int'(aw_idx)*3 +: 3]             = m_awsize;
          s_awburst[int'(aw_idx)*2 +: 2]            = m_awburst;
          m_awready                                 = s_awready[aw_idx];
          if (m_awvalid && s_awready[aw_idx]) begin
            wsel_nxt   = aw_idx;
            werr_nxt   = 1'b0;
            wstate_nxt = W_DATA;
          end
        end else begin
          m_awready = 1'b1;
          if (m_awvalid) begin
            bid_nxt    = m_awid;
            werr_nxt   = 1'b1;
            wstate_nxt = W_DATA;
          end
        end
      end
      W_DATA: begin
        if (werr) begin
          m_wready = 1'b1;
          if (m_wvalid && m_wlast)
            wstate_nxt = W_RESP;
        end else begin
          s_wvalid[wsel]                            = m_wvalid;
          s_wdata[int'(wsel)*DATA_W +: DATA_W]      = m_wdata;
          s_wstrb[int'(wsel)*STRB_W +: STRB_W]      = m_wstrb;
          s_wlast[wsel]                             = m_wlast;
          m_wready                                  = s_wready[wsel];
          if (m_wvalid && s_wready[wsel] && m_wlast)
            wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (werr) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
          m_bid    = bid_q;
          if (m_bready)
            wstate_nxt = W_IDLE;
        end else begin
          m_bvalid       = s_bvalid[wsel];
          m_bresp        = s_bresp[int'(wsel)*2 +: 2];
          m_bid          = s_bid[int'(wsel)*ID_W +: ID_W];
          s_bready[wsel] = m_bready;
          if (s_bvalid[wsel] && m_bready)
            wstate_nxt = W_IDLE;
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar_1ton.sv
// tb_axi_xbar_1ton: randomized scoreboard bench for axi_xbar_1ton.
// Drivers push expected R beats, W beats and B responses into queues. A
// single environment process models the slaves and the master's ready
// signals, and it pops and compares the queues on every handshake.
module tb_axi_xbar_1ton;
  localparam int NS = 2;
  localparam logic [63:0] BASE = {32'h8000_0000, 32'h0200_0000};
  localparam logic [63:0] MASK = {32'hF000_0000, 32'hFFFF_0000};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_bid, m_wstrb;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic [NS-1:0]    s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [NS*32-1:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [NS*4-1:0]  s_arid, s_rid, s_awid, s_bid, s_wstrb;
  logic [NS*8-1:0]  s_arlen, s_awlen;
  logic [NS*3-1:0]  s_arsize, s_awsize;
  logic [NS*2-1:0]  s_arburst, s_rresp, s_awburst, s_bresp;
  logic [NS-1:0]    s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic [NS-1:0]    s_bvalid, s_bready;

  axi_xbar_1ton #(.NSLV(NS), .ADDR_W(32), .DATA_W(32), .ID_W(4),
                  .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready)
  );

  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} rb_t;
  typedef struct packed {logic [1:0] slv; logic [31:0] data; logic [3:0] strb; logic last;} wb_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} bb_t;

  rb_t rexp[$];
  wb_t wexp[$];
  bb_t bexp[$];
  int total = 0, bad = 0;
  int rdone = 0, rbeats = 0, bdone = 0;
  int slow_slv = -1;  // this slave waits exactly 2 cycles before every R beat
  int bhold = 0;      // cycles m_bready is held low once B is offered

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // lowest-index slave whose masked base equals the masked address
  function automatic void ref_dec(input logic [31:0] a, output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int i = 0; i < NS; i++)
      if (!hit && ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32])) begin
        hit = 1;
        idx = i;
      end
  endfunction

  // memory contents and response code of each modelled slave
  function automatic logic [31:0] sdata(input int i, input logic [31:0] a, input int k);
    return (a + 32'(k) * 32'd4) ^ (32'hA5A5_0000 + 32'(i) * 32'h0001_1111);
  endfunction

  function automatic logic [1:0] sresp(input int i);
    return (i == 1) ? 2'b01 : 2'b00;
  endfunction

  // slaves, master ready generation and the scoreboard monitor
  initial begin : env
    bit          rbusy[NS];
    int          rlen[NS], rbeat[NS], rwait[NS], wph[NS];
    logic [31:0] raddr[NS];
    logic [3:0]  rid[NS], wid[NS];
    int          bwait;
    bit          in_rst;
    rb_t re;
    wb_t we;
    bb_t be;
    bwait = 0;
    in_rst = 1;
    for (int i = 0; i < NS; i++) begin
      rbusy[i] = 0; rlen[i] = 0; rbeat[i] = 0; rwait[i] = 0; wph[i] = 0;
      raddr[i] = '0; rid[i] = '0; wid[i] = '0;
    end
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rid = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0; s_bid = '0;
    m_rready = 0; m_bready = 0;
    forever begin
      @(negedge clock);
      in_rst = reset;
      if (reset) begin
        for (int i = 0; i < NS; i++) begin
          rbusy[i] = 0; wph[i] = 0;
        end
        bwait = 0;
        rexp.delete();
        wexp.delete();
        bexp.delete();
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (s_arvalid[i] && s_arready[i]) begin
            rbusy[i] = 1;
            rlen[i]  = int'(s_arlen[i*8 +: 8]);
            rbeat[i] = 0;
            raddr[i] = s_araddr[i*32 +: 32];
            rid[i]   = s_arid[i*4 +: 4];
            rwait[i] = (i == slow_slv) ? 2 : int'($urandom % 2);
          end else if (rbusy[i] && s_rvalid[i] && s_rready[i]) begin
            if (rbeat[i] == rlen[i]) rbusy[i] = 0;
            else begin
              rbeat[i]++;
              rwait[i] = (i == slow_slv) ? 2 : int'($urandom % 2);
            end
          end
          if (s_awvalid[i] && s_awready[i]) begin
            wph[i] = 1;
            wid[i] = s_awid[i*4 +: 4];
          end
          if (s_wvalid[i] && s_wready[i]) begin
            if (wexp.size() == 0) fail("w_unexpected_beat");
            else begin
              we = wexp.pop_front();
              chk("w_slave", i, we.slv);
              chk("w_data", s_wdata[i*32 +: 32], we.data);
              chk("w_strb", s_wstrb[i*4 +: 4], we.strb);
              chk("w_last", s_wlast[i], we.last);
            end
            if (s_wlast[i]) wph[i] = 2;
          end
          if (s_bvalid[i] && s_bready[i]) wph[i] = 0;
        end
        if (m_rvalid && m_rready) begin
          if (rexp.size() == 0) fail("r_unexpected_beat");
          else begin
            re = rexp.pop_front();
            chk("r_data", m_rdata, re.data);
            chk("r_resp", m_rresp, re.resp);
            chk("r_id", m_rid, re.id);
            chk("r_last", m_rlast, re.last);
          end
          rbeats++;
          if (m_rlast) rdone++;
        end
        if (m_bvalid && m_bready) begin
          if (bexp.size() == 0) fail("b_unexpected");
          else begin
            be = bexp.pop_front();
            chk("b_id", m_bid, be.id);
            chk("b_resp", m_bresp, be.resp);
          end
          bdone++;
          bwait = 0;
        end else if (m_bvalid) bwait++;
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NS; i++) begin
        s_arready[i] = !in_rst && !rbusy[i] && ($urandom % 3 != 0);
        s_rvalid[i] = 0; s_rdata[i*32 +: 32] = '0; s_rresp[i*2 +: 2] = '0;
        s_rlast[i] = 0; s_rid[i*4 +: 4] = '0;
        if (!in_rst && rbusy[i]) begin
          if (rwait[i] > 0) rwait[i]--;
          else begin
            s_rvalid[i]          = 1;
            s_rdata[i*32 +: 32]  = sdata(i, raddr[i], rbeat[i]);
            s_rresp[i*2 +: 2]    = sresp(i);
            s_rlast[i]           = (rbeat[i] == rlen[i]);
            s_rid[i*4 +: 4]      = rid[i];
          end
        end
        s_awready[i] = !in_rst && wph[i] == 0 && ($urandom % 3 != 0);
        s_wready[i]  = !in_rst && wph[i] == 1 && ($urandom % 3 != 0);
        s_bvalid[i]  = !in_rst && wph[i] == 2;
        s_bresp[i*2 +: 2] = s_bvalid[i] ? sresp(i) : 2'b00;
        s_bid[i*4 +: 4]   = s_bvalid[i] ? wid[i] : 4'h0;
      end
      m_rready = !in_rst && ($urandom % 4 != 0);
      m_bready = !in_rst && (bwait >= bhold) && (bhold > 0 || $urandom % 4 != 0);
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                         input bit wait_done, input bit move_addr);
    bit hit;
    int idx, t, n0;
    rb_t re;
    ref_dec(a, hit, idx);
    for (int k = 0; k <= int'(len); k++) begin
      re.data = hit ? sdata(idx, a, k) : 32'h0;
      re.resp = hit ? sresp(idx) : 2'b11;
      re.id   = id;
      re.last = (k == int'(len));
      rexp.push_back(re);
    end
    n0 = rdone;
    m_arvalid = 1; m_araddr = a; m_arid = id; m_arlen = len; m_arsize = 3'd2; m_arburst = 2'd1;
    t = 0;
    forever begin
      @(negedge clock);
      chk("ar_route", s_arvalid, hit ? (64'd1 << idx) : 64'd0);
      if (hit) chk("ar_addr", s_araddr[idx*32 +: 32], a);
      if (m_arready) break;
      t++;
      if (t > 200) begin fail("ar_timeout"); break; end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    m_arvalid = 0; m_araddr = move_addr ? 32'h0200_0000 : 32'h0; m_arid = '0; m_arlen = '0;
    if (wait_done) begin
      t = 0;
      while (rdone == n0 && t < 2000) begin
        @(posedge clock);
        #1;
        t++;
      end
      if (rdone == n0) fail("r_done_timeout");
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                          input int pre);
    bit hit;
    int idx, t, n0;
    logic [31:0] wd[256];
    logic [3:0]  ws[256];
    wb_t we;
    bb_t be;
    ref_dec(a, hit, idx);
    for (int k = 0; k <= int'(len); k++) begin
      wd[k] = $urandom;
      ws[k] = 4'($urandom);
      if (hit) begin
        we.slv = 2'(idx); we.data = wd[k]; we.strb = ws[k]; we.last = (k == int'(len));
        wexp.push_back(we);
      end
    end
    be.id = id;
    be.resp = hit ? sresp(idx) : 2'b11;
    bexp.push_back(be);
    n0 = bdone;
    if (pre > 0) begin
      m_wvalid = 1; m_wdata = wd[0]; m_wstrb = ws[0]; m_wlast = (len == 8'd0);
      for (int c = 0; c < pre; c++) begin
        @(negedge clock);
        chk("w_stall_pre_aw", m_wready, 0);
        @(posedge clock);
        #1;
      end
    end
    m_awvalid = 1; m_awaddr = a; m_awid = id; m_awlen = len; m_awsize = 3'd2; m_awburst = 2'd1;
    t = 0;
    forever begin
      @(negedge clock);
      chk("aw_route", s_awvalid, hit ? (64'd1 << idx) : 64'd0);
      if (pre > 0) chk("w_stall_aw", m_wready, 0);
      if (m_awready) break;
      t++;
      if (t > 200) begin fail("aw_timeout"); break; end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    m_awvalid = 0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
    for (int k = 0; k <= int'(len); k++) begin
      m_wvalid = 1; m_wdata = wd[k]; m_wstrb = ws[k]; m_wlast = (k == int'(len));
      t = 0;
      forever begin
        @(negedge clock);
        if (m_wready) break;
        t++;
        if (t > 200) begin fail("w_timeout"); break; end
        @(posedge clock);
        #1;
      end
      @(posedge clock);
      #1;
    end
    m_wvalid = 0; m_wdata = '0; m_wstrb = '0; m_wlast = 0;
    t = 0;
    while (bdone == n0 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (bdone == n0) fail("b_done_timeout");
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 4)
      0: return 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
      1: return 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      2: return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      default: return 32'h0201_0000 | ($urandom & 32'h0000_FFFC);
    endcase
  endfunction

  initial begin : main
    int n0, t;
    m_arvalid = 0; m_araddr = 32'h0200_0000; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_awvalid = 0; m_awaddr = 32'h8000_0000; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = 0; m_wdata = '0; m_wstrb = '0; m_wlast = 0;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_m_awready", m_awready, 0);
    chk("rst_m_wready", m_wready, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_m_bvalid", m_bvalid, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_s_bready", s_bready, 0);
    @(posedge clock);
    #1;
    reset = 0;
    repeat (2) @(posedge clock);
    #1;

    do_read(32'h0200_0004, 8'd0, 4'h1, 1, 0);
    slow_slv = 1;
    do_read(32'h8000_0000, 8'd3, 4'h2, 1, 1);
    slow_slv = -1;
    do_read(32'h1000_0000, 8'd2, 4'h5, 1, 0);
    bhold = 3;
    do_write(32'h8000_0010, 8'd1, 4'h3, 2);
    bhold = 0;
    fork
      do_read(32'h0200_0000, 8'd1, 4'h6, 1, 0);
      do_write(32'h8000_0000, 8'd2, 4'h7, 0);
    join
    do_write(32'h3000_0000, 8'd1, 4'h8, 0);
    do_read(32'h4000_0000, 8'd255, 4'h9, 1, 0);

    // reset in the middle of a 4-beat read
    slow_slv = 1;
    n0 = rbeats;
    do_read(32'h8000_0000, 8'd3, 4'hA, 0, 0);
    t = 0;
    while (rbeats < n0 + 2 && t < 500) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (rbeats < n0 + 2) fail("rst_burst_timeout");
    reset = 1;
    n0 = rdone;
    @(posedge clock);
    #1;
    reset = 0;
    m_araddr = 32'h8000_0000;
    @(negedge clock);
    chk("rst_mid_rvalid", m_rvalid, 0);
    chk("rst_mid_arready", m_arready, s_arready[1]);
    chk("rst_mid_s_arvalid", s_arvalid, 0);
    chk("rst_mid_rdone", rdone, n0);
    @(posedge clock);
    #1;
    slow_slv = -1;
    do_read(32'h8000_0004, 8'd1, 4'hB, 1, 0);

    fork
      begin
        for (int n = 0; n < 30; n++)
          do_read(rand_addr(), 8'($urandom % 8), 4'($urandom), 1, 0);
      end
      begin
        for (int n = 0; n < 30; n++)
          do_write(rand_addr(), 8'($urandom % 8), 4'($urandom), int'($urandom % 3));
      end
    join

    repeat (5) @(posedge clock);
    chk("rexp_empty", rexp.size(), 0);
    chk("wexp_empty", wexp.size(), 0);
    chk("bexp_empty", bexp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
